// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter FSM states and the line idle level.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_ODD      = 2'b01,
        PAR_EVEN     = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    function automatic logic parity_used(input parity_e p);
        return (p == PAR_ODD) || (p == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Payload buffer for the UART transmitter; a push and a pop may share a cycle even when full.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start/data/parity/stop framing with configuration latched per frame.
// Define UART_TX_FIFO_EN to buffer payloads in a FIFO_DEPTH-entry uart_tx_fifo.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_type,
    input  logic              stop_bits,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              data_tx,
    output logic              active_flag,
    output logic              done_flag
);
    localparam int               IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    if (DATA_W < 5 || DATA_W > 9 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_engine: illegal DATA_W or FIFO_DEPTH");
    end

    tx_state_e         state;
    logic [DIV_W-1:0]  cnt, div_q;
    parity_e           par_q;
    logic              stop2_q, stop_idx, par_bit, ready_q;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;

    logic              bit_end, stop_done, take, push_req, start_avail, load;
    logic [DATA_W-1:0] next_data;

    assign bit_end   = (cnt == div_q);
    assign stop_done = (state == ST_STOP) && bit_end && (!stop2_q || stop_idx);
    assign take      = (state == ST_IDLE) || stop_done;
    assign push_req  = tx_valid && tx_ready;
    assign load      = take && start_avail;

`ifdef UART_TX_FIFO_EN
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    // An empty FIFO is bypassed so a lone payload still starts one clock after acceptance.
    assign fifo_pop    = take && !fifo_empty;
    assign fifo_push   = push_req && !(take && fifo_empty);
    assign start_avail = !fifo_empty || push_req;
    assign next_data   = fifo_empty ? tx_data : fifo_dout;
    assign tx_ready    = ready_q && !fifo_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (tx_data),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );
`else
    assign start_avail = push_req;
    assign next_data   = tx_data;
    assign tx_ready    = ready_q && (state == ST_IDLE);
`endif

    // Control: state, bit timing and registered line outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            ready_q     <= 1'b0;
            data_tx     <= IDLE_LEVEL;
            active_flag <= 1'b0;
            done_flag   <= 1'b0;
        end else begin
            ready_q   <= 1'b1;
            done_flag <= stop_done;
            if (load) begin
                state       <= ST_START;
                cnt         <= '0;
                bit_idx     <= '0;
                stop_idx    <= 1'b0;
                data_tx     <= ~IDLE_LEVEL;
                active_flag <= 1'b1;
            end else if (state != ST_IDLE) begin
                cnt <= bit_end ? '0 : cnt + DIV_W'(1);
                if (bit_end) begin
                    case (state)
                        ST_START: begin
                            state   <= ST_DATA;
                            data_tx <= shreg[0];
                        end
                        ST_DATA: begin
                            if (bit_idx != LAST_IDX) begin
                                bit_idx <= bit_idx + IDX_W'(1);
                                data_tx <= shreg[0];
                            end else if (parity_used(par_q)) begin
                                state   <= ST_PARITY;
                                data_tx <= par_bit;
                            end else begin
                                state   <= ST_STOP;
                                data_tx <= IDLE_LEVEL;
                            end
                        end
                        ST_PARITY: begin
                            state   <= ST_STOP;
                            data_tx <= IDLE_LEVEL;
                        end
                        ST_STOP: begin
                            if (stop_done) begin
                                state       <= ST_IDLE;
                                active_flag <= 1'b0;
                            end else begin
                                stop_idx <= 1'b1;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Datapath: per-frame configuration and payload shifter, loaded on entry to START.
    always_ff @(posedge clock) begin
        if (load) begin
            div_q   <= baud_div;
            par_q   <= parity_e'(parity_type);
            stop2_q <= stop_bits;
            shreg   <= next_data;
            par_bit <= (^next_data) ^ (parity_e'(parity_type) == PAR_ODD);
        end else if (bit_end && (state == ST_START || state == ST_DATA)) begin
            shreg <= shreg >> 1;
        end
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame, legal 5..9.
REQ-002 SHALL have parameter DIV_W, default 16, baud divisor width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, TX buffer entries, power of two >= 2; used only when UART_TX_FIFO_EN is defined.
REQ-004 SHALL have port clock, input, 1, the only clock; all state on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port baud_div, input, DIV_W, clocks per bit minus one.
REQ-007 SHALL have port parity_type, input, 2: 00 none, 01 odd, 10 even, 11 none.
REQ-008 SHALL have port stop_bits, input, 1: 0 one stop bit, 1 two stop bits.
REQ-009 SHALL have port tx_data, input, DATA_W, payload.
REQ-010 SHALL have port tx_valid, input, 1, payload offered.
REQ-011 SHALL have port tx_ready, output, 1, payload accepted when tx_valid && tx_ready.
REQ-012 SHALL have port data_tx, output, 1, serial line, idle high.
REQ-013 SHALL have port active_flag, output, 1, high while a frame is on the line.
REQ-014 SHALL have port done_flag, output, 1, one-cycle pulse at frame end.

Function
REQ-015 SHALL run FSM IDLE -> START -> DATA -> PARITY -> STOP -> IDLE; skip PARITY when parity_type is 00 or 11.
REQ-016 SHALL hold each bit for exactly baud_div+1 clocks; baud_div=0 gives one clock per bit.
REQ-017 SHALL latch baud_div, parity_type, stop_bits and payload on entry to START; changes mid-frame have no effect until the next frame.
REQ-018 SHALL drive START low; send DATA LSB first, DATA_W bits; send PARITY as XOR of payload (even) or its inverse (odd); hold STOP high for 1 or 2 bit times.
REQ-019 SHALL set data_tx low on the clock after an accepted handshake in IDLE (one-cycle latency).
REQ-020 SHALL assert active_flag from entry to START to the last clock of STOP inclusive.
REQ-021 SHALL pulse done_flag for one clock on the cycle after the last STOP clock.
REQ-022 SHALL, when another payload is pending at STOP end, enter START directly with no idle bit; done_flag still pulses.
REQ-023 SHALL, without FIFO, drive tx_ready = (state == IDLE); tx_valid while not ready is ignored and the payload is not consumed.

Reset
REQ-024 SHALL, on reset_n low, immediately force data_tx=1, active_flag=0, done_flag=0, state IDLE, baud counter 0, FIFO empty.
REQ-025 SHALL abort a frame in progress on reset; no done_flag pulse for the aborted frame.
REQ-026 SHALL drive tx_ready=0 during reset and 1 from the first clock after release.

Configuration
REQ-027 SHALL, with UART_TX_FIFO_EN defined, buffer payloads in a FIFO_DEPTH-entry FIFO; tx_ready = !full; the FSM pops on leaving IDLE or STOP.
REQ-028 SHALL, with UART_TX_FIFO_EN defined, accept a push and a pop in the same cycle when full; occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-029 SHALL, without UART_TX_FIFO_EN, contain no FIFO storage and behave as in REQ-023.

Structure
REQ-030 SHALL take parity encodings, FSM state enum and the IDLE_LEVEL constant from shared package uart_pkg.
REQ-031 SHALL place the FIFO in sub-module uart_tx_fifo (parameter DEPTH, WIDTH), instantiated only under UART_TX_FIFO_EN.

Verification
REQ-032 SHALL check: DATA_W=8, baud_div=3, even parity, 1 stop, send 0xA5 -> data_tx 0,1,0,1,0,0,1,0,1,0,1, each held 4 clocks; done_flag pulses 44 clocks after the line goes low.
REQ-033 SHALL check: odd parity, send 0x00 -> parity bit 1; parity_type 11 -> no parity bit, 10-bit frame.
REQ-034 SHALL check: stop_bits=1, no parity, baud_div=0, send 0xFF -> 11-clock frame, last 3 clocks high.
REQ-035 SHALL check: FIFO_EN, FIFO_DEPTH=4, 5 back-to-back valids -> tx_ready low after 5 accepts (4 queued + 1 in flight), frames contiguous with no idle bit, 5 done_flag pulses.
REQ-036 SHALL check: reset_n low mid-DATA -> data_tx=1 and active_flag=0 within the same cycle; no done_flag; the next frame is correct.
REQ-037 SHALL check: baud_div changed 10->2 mid-frame -> current frame keeps 11 clocks per bit; the next frame uses 3.
